// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: commits trap and mret state, holds the
// fetch redirect, serves CSR instructions and runs mcycle/minstret.
module trap_csr_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            trapRequest,
    input  logic [3:0]      trapCause,
    input  logic [XLEN-1:0] trapPc,
    input  logic [XLEN-1:0] trapValue,
    input  logic            mretRequest,
    input  logic            csrValid,
    input  logic [1:0]      csrOp,
    input  logic [11:0]     csrAddress,
    input  logic [XLEN-1:0] csrWriteData,
    input  logic            retireValid,
    input  logic            redirectReady,
    output logic [XLEN-1:0] csrReadData,
    output logic            csrIllegal,
    output logic            redirectValid,
    output logic [XLEN-1:0] redirectPc,
    output logic            interruptEnable
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;

    localparam logic [1:0] OP_RW = 2'b01;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t state;

    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic            valid_q;
    logic [XLEN-1:0] target_q;

    logic [XLEN-1:0] old_value;
    logic            mapped;
    logic            hartid_write;
    logic [XLEN-1:0] write_value;
    logic            changes_value;
    logic            do_write;

    logic            wr_mstatus;
    logic            wr_mtvec;
    logic            wr_mscratch;
    logic            wr_mepc;
    logic            wr_mcause;
    logic            wr_mtval;
    logic            wr_mcycle;
    logic            wr_mcycleh;
    logic            wr_minstret;
    logic            wr_minstreth;

    // Decode the addressed CSR into its current (pre-edge) value.
    always_comb begin
        old_value = '0;
        mapped    = 1'b1;
        case (csrAddress)
            ADDR_MSTATUS:   old_value = {24'b0, mpie, 3'b0, mie, 3'b0};
            ADDR_MISA:      old_value = MISA_VALUE;
            ADDR_MTVEC:     old_value = mtvec;
            ADDR_MSCRATCH:  old_value = mscratch;
            ADDR_MEPC:      old_value = mepc;
            ADDR_MCAUSE:    old_value = mcause;
            ADDR_MTVAL:     old_value = mtval;
            ADDR_MCYCLE:    old_value = mcycle[31:0];
            ADDR_MCYCLEH:   old_value = mcycle[63:32];
            ADDR_MINSTRET:  old_value = minstret[31:0];
            ADDR_MINSTRETH: old_value = minstret[63:32];
            ADDR_MHARTID:   old_value = '0;
            default:        mapped    = 1'b0;
        endcase
    end

    // Form the write value and decide whether this cycle commits it.
    always_comb begin
        hartid_write = (csrAddress == ADDR_MHARTID) &&
                       ((csrOp == OP_RW) || (csrWriteData != '0));
        csrIllegal   = csrValid && (!mapped || hartid_write);
        case (csrOp)
            2'b01:   write_value = csrWriteData;
            2'b10:   write_value = old_value | csrWriteData;
            2'b11:   write_value = old_value & ~csrWriteData;
            default: write_value = old_value;
        endcase
        changes_value = (csrOp == OP_RW) ||
                        (csrOp[1] && (csrWriteData != '0));
        do_write = csrValid && changes_value && !csrIllegal &&
                   !trapRequest && !mretRequest;
    end

    // Per-register write strobes.
    always_comb begin
        wr_mstatus   = do_write && (csrAddress == ADDR_MSTATUS);
        wr_mtvec     = do_write && (csrAddress == ADDR_MTVEC);
        wr_mscratch  = do_write && (csrAddress == ADDR_MSCRATCH);
        wr_mepc      = do_write && (csrAddress == ADDR_MEPC);
        wr_mcause    = do_write && (csrAddress == ADDR_MCAUSE);
        wr_mtval     = do_write && (csrAddress == ADDR_MTVAL);
        wr_mcycle    = do_write && (csrAddress == ADDR_MCYCLE);
        wr_mcycleh   = do_write && (csrAddress == ADDR_MCYCLEH);
        wr_minstret  = do_write && (csrAddress == ADDR_MINSTRET);
        wr_minstreth = do_write && (csrAddress == ADDR_MINSTRETH);
    end

    // Redirect FSM: a trap or mret (re)loads the target and holds valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            if (trapRequest || mretRequest) begin
                state    <= REDIRECT;
                valid_q  <= 1'b1;
                target_q <= trapRequest ? mtvec : mepc;
            end else begin
                case (state)
                    IDLE: begin
                        valid_q <= 1'b0;
                    end
                    REDIRECT: begin
                        if (redirectReady) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Architectural CSRs: trap beats mret beats instruction writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (trapRequest) begin
            mepc   <= {trapPc[XLEN-1:2], 2'b00};
            mcause <= {{(XLEN-4){1'b0}}, trapCause};
            mtval  <= trapValue;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mretRequest) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else begin
            if (wr_mstatus) begin
                mie  <= write_value[3];
                mpie <= write_value[7];
            end
            if (wr_mtvec) begin
                mtvec <= {write_value[XLEN-1:2], 2'b00};
            end
            if (wr_mscratch) begin
                mscratch <= write_value;
            end
            if (wr_mepc) begin
                mepc <= {write_value[XLEN-1:2], 2'b00};
            end
            if (wr_mcause) begin
                mcause <= write_value;
            end
            if (wr_mtval) begin
                mtval <= write_value;
            end
        end
    end

    // 64-bit counters; a write to either half replaces the increment.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_mcycle) begin
                mcycle[31:0] <= write_value;
            end else if (wr_mcycleh) begin
                mcycle[63:32] <= write_value;
            end else begin
                mcycle <= mcycle + 64'd1;
            end
            if (wr_minstret) begin
                minstret[31:0] <= write_value;
            end else if (wr_minstreth) begin
                minstret[63:32] <= write_value;
            end else if (retireValid) begin
                minstret <= minstret + 64'd1;
            end
        end
    end

    assign csrReadData     = old_value;
    assign redirectValid   = valid_q;
    assign redirectPc      = target_q;
    assign interruptEnable = mie;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: trap/mret commit, redirect
// handshake, CSR access rules and 64-bit counter carry/wrap.
module tb_trap_csr_unit;

    logic        clock;
    logic        reset;
    logic        trapRequest;
    logic [3:0]  trapCause;
    logic [31:0] trapPc;
    logic [31:0] trapValue;
    logic        mretRequest;
    logic        csrValid;
    logic [1:0]  csrOp;
    logic [11:0] csrAddress;
    logic [31:0] csrWriteData;
    logic        retireValid;
    logic        redirectReady;
    logic [31:0] csrReadData;
    logic        csrIllegal;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        interruptEnable;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rv;
    logic [31:0] lo;

    trap_csr_unit #(.XLEN(32)) dut (
        .clock(clock),
        .reset(reset),
        .trapRequest(trapRequest),
        .trapCause(trapCause),
        .trapPc(trapPc),
        .trapValue(trapValue),
        .mretRequest(mretRequest),
        .csrValid(csrValid),
        .csrOp(csrOp),
        .csrAddress(csrAddress),
        .csrWriteData(csrWriteData),
        .retireValid(retireValid),
        .redirectReady(redirectReady),
        .csrReadData(csrReadData),
        .csrIllegal(csrIllegal),
        .redirectValid(redirectValid),
        .redirectPc(redirectPc),
        .interruptEnable(interruptEnable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        csrValid     = 1'b1;
        csrOp        = 2'b10;
        csrAddress   = addr;
        csrWriteData = 32'h0;
        #1;
        data     = csrReadData;
        csrValid = 1'b0;
        csrOp    = 2'b00;
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] data);
        csrValid     = 1'b1;
        csrOp        = op;
        csrAddress   = addr;
        csrWriteData = data;
        step();
        csrValid     = 1'b0;
        csrOp        = 2'b00;
        csrWriteData = 32'h0;
    endtask

    task automatic trap(input logic [3:0] cause, input logic [31:0] pc,
                        input logic [31:0] val);
        trapRequest = 1'b1;
        trapCause   = cause;
        trapPc      = pc;
        trapValue   = val;
        step();
        trapRequest = 1'b0;
    endtask

    task automatic accept();
        redirectReady = 1'b1;
        step();
        redirectReady = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        trapRequest   = 1'b0;
        trapCause     = 4'h0;
        trapPc        = 32'h0;
        trapValue     = 32'h0;
        mretRequest   = 1'b0;
        csrValid      = 1'b0;
        csrOp         = 2'b00;
        csrAddress    = 12'h0;
        csrWriteData  = 32'h0;
        retireValid   = 1'b0;
        redirectReady = 1'b0;
        step();
        step();

        chk("rst_valid", {31'b0, redirectValid}, 32'h0);
        chk("rst_pc", redirectPc, 32'h0);
        chk("rst_ie", {31'b0, interruptEnable}, 32'h0);
        rd(12'h305, rv); chk("rst_mtvec", rv, 32'h0);
        rd(12'hB00, rv); chk("rst_mcycle", rv, 32'h0);
        rd(12'h301, rv); chk("misa", rv, 32'h4000_0100);
        reset = 1'b1;

        rd(12'hB00, lo);
        step(); step(); step();
        rd(12'hB00, rv); chk("mcycle_run", rv, lo + 32'd3);

        wr(2'b01, 12'h305, 32'h8000_0103);
        rd(12'h305, rv); chk("mtvec_mask", rv, 32'h8000_0100);

        trap(4'd2, 32'h0000_1006, 32'h0000_0055);
        chk("t1_valid", {31'b0, redirectValid}, 32'h1);
        chk("t1_pc", redirectPc, 32'h8000_0100);
        chk("t1_ie", {31'b0, interruptEnable}, 32'h0);
        rd(12'h341, rv); chk("t1_mepc", rv, 32'h0000_1004);
        rd(12'h342, rv); chk("t1_mcause", rv, 32'h2);
        rd(12'h343, rv); chk("t1_mtval", rv, 32'h55);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", {31'b0, redirectValid}, 32'h1);
            chk("hold_pc", redirectPc, 32'h8000_0100);
        end
        accept();
        chk("acc_valid", {31'b0, redirectValid}, 32'h0);

        wr(2'b10, 12'h300, 32'h8);
        chk("rs_ie", {31'b0, interruptEnable}, 32'h1);
        rd(12'h300, rv); chk("rs_mstatus", rv, 32'h8);
        trap(4'd3, 32'h0000_2000, 32'h0);
        chk("t2_ie", {31'b0, interruptEnable}, 32'h0);
        rd(12'h300, rv); chk("t2_mstatus", rv, 32'h80);
        accept();
        mretRequest = 1'b1;
        step();
        mretRequest = 1'b0;
        chk("mret_valid", {31'b0, redirectValid}, 32'h1);
        chk("mret_pc", redirectPc, 32'h0000_2000);
        chk("mret_ie", {31'b0, interruptEnable}, 32'h1);
        rd(12'h300, rv); chk("mret_mstatus", rv, 32'h88);
        accept();

        wr(2'b01, 12'h340, 32'h0000_AAAA);
        csrValid     = 1'b1;
        csrOp        = 2'b01;
        csrAddress   = 12'h340;
        csrWriteData = 32'h0000_1234;
        trap(4'd5, 32'h0000_3000, 32'h0);
        csrValid = 1'b0;
        csrOp    = 2'b00;
        rd(12'h340, rv); chk("trap_blocks_wr", rv, 32'h0000_AAAA);
        rd(12'h342, rv); chk("t3_mcause", rv, 32'h5);
        accept();

        mretRequest = 1'b1;
        trap(4'd7, 32'h0000_4000, 32'h0);
        mretRequest = 1'b0;
        chk("prio_pc", redirectPc, 32'h8000_0100);
        rd(12'h342, rv); chk("prio_mcause", rv, 32'h7);
        rd(12'h341, rv); chk("prio_mepc", rv, 32'h0000_4000);
        chk("prio_ie", {31'b0, interruptEnable}, 32'h0);
        accept();

        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB80, 32'h0);
        rd(12'hB00, rv); chk("cyc_lo_pre", rv, 32'hFFFF_FFFF);
        rd(12'hB80, rv); chk("cyc_hi_pre", rv, 32'h0);
        step();
        rd(12'hB80, rv); chk("cyc_carry_hi", rv, 32'h1);
        rd(12'hB00, rv); chk("cyc_carry_lo", rv, 32'h0);

        wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        rd(12'hB80, rv); chk("wrap_hi", rv, 32'h0);
        rd(12'hB00, rv); chk("wrap_lo", rv, 32'h0);

        wr(2'b01, 12'hB02, 32'h5);
        retireValid = 1'b1;
        step(); step();
        retireValid = 1'b0;
        rd(12'hB02, rv); chk("minstret", rv, 32'h7);

        csrValid     = 1'b1;
        csrOp        = 2'b01;
        csrAddress   = 12'hF14;
        csrWriteData = 32'h1;
        #1;
        chk("hart_illegal", {31'b0, csrIllegal}, 32'h1);
        chk("hart_read", csrReadData, 32'h0);
        step();
        csrOp        = 2'b10;
        csrWriteData = 32'h0;
        #1;
        chk("hart_read_ok", {31'b0, csrIllegal}, 32'h0);
        csrAddress = 12'h7C0;
        #1;
        chk("unmapped", {31'b0, csrIllegal}, 32'h1);
        csrValid = 1'b0;
        csrOp    = 2'b00;
        #1;
        rd(12'hF14, rv); chk("hart_nochg", rv, 32'h0);
        rd(12'h340, rv); chk("hart_mscratch", rv, 32'h0000_AAAA);
        wr(2'b01, 12'h301, 32'h0);
        rd(12'h301, rv); chk("misa_ro", rv, 32'h4000_0100);

        trap(4'd4, 32'h0000_5000, 32'h0);
        wr(2'b01, 12'h305, 32'h0000_0200);
        chk("re_hold", {31'b0, redirectValid}, 32'h1);
        trap(4'd6, 32'h0000_6004, 32'h0);
        chk("re_pc", redirectPc, 32'h0000_0200);
        chk("re_valid", {31'b0, redirectValid}, 32'h1);
        rd(12'h342, rv); chk("re_mcause", rv, 32'h6);
        rd(12'h341, rv); chk("re_mepc", rv, 32'h0000_6004);

        reset = 1'b0;
        step();
        chk("mid_rst_valid", {31'b0, redirectValid}, 32'h0);
        chk("mid_rst_pc", redirectPc, 32'h0);
        rd(12'h305, rv); chk("mid_rst_mtvec", rv, 32'h0);
        reset = 1'b1;
        step();
        chk("post_rst_valid", {31'b0, redirectValid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
